// File: rtl/seq_alu.sv
// seq_alu: clocked ALU with registered single-cycle ops and iterative shift-add multiply / restoring divide.
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic [WIDTH-1:0]   d0_in,
    input  logic [WIDTH-1:0]   d1_in,
    input  logic [2:0]         sel_in,
    input  logic               valid_in,
    output logic               ready_out,
    output logic [2*WIDTH-1:0] res_out,
    output logic               gt_out,
    output logic               eq_out,
    output logic               div_zero_out,
    output logic               valid_out
);
    localparam int W2 = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W2-1:0]   acc_q, acc_d, mc_q, mc_d;
    logic [WIDTH-1:0] mp_q, mp_d, quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic            gtp_q, gtp_d, eqp_q, eqp_d;
    logic [W2-1:0]   res_q, res_d;
    logic            gt_q, gt_d, eq_q, eq_d, dz_q, dz_d, vld_q, vld_d;

    logic            accept, last, multi;
    logic [W2-1:0]   alu, mul_acc;
    logic [WIDTH:0]  div_r;
    logic            div_ge;
    logic [WIDTH-1:0] div_rn, div_qn;

    assign accept  = valid_in && state_q == IDLE;
    assign last    = cnt_q == CW'(WIDTH - 1);
    assign multi   = sel_in == 3'd5 || sel_in == 3'd6;
    assign alu     = sel_in == 3'd0 ? W2'(d0_in) + W2'(d1_in) :
                     sel_in == 3'd1 ? W2'(d0_in) - W2'(d1_in) :
                     sel_in == 3'd2 ? W2'(d0_in & d1_in) :
                     sel_in == 3'd3 ? W2'(d0_in | d1_in) :
                     sel_in == 3'd4 ? W2'(d0_in ^ d1_in) : {d1_in, d0_in};
    assign mul_acc = mp_q[0] ? acc_q + mc_q : acc_q;
    // The true remainder always fits WIDTH bits, so the subtraction can wrap at WIDTH.
    assign div_r   = {rem_q, quo_q[WIDTH-1]};
    assign div_ge  = div_r >= {1'b0, dvs_q};
    assign div_rn  = div_ge ? div_r[WIDTH-1:0] - dvs_q : div_r[WIDTH-1:0];
    assign div_qn  = {quo_q[WIDTH-2:0], div_ge};

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mc_q    <= '0;
            mp_q    <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            gtp_q   <= 1'b0;
            eqp_q   <= 1'b0;
            res_q   <= '0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            dz_q    <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mc_q    <= mc_d;
            mp_q    <= mp_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            gtp_q   <= gtp_d;
            eqp_q   <= eqp_d;
            res_q   <= res_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            dz_q    <= dz_d;
            vld_q   <= vld_d;
        end
    end

    always_comb begin
        state_d = state_q == IDLE ? (accept && sel_in == 3'd5 ? MUL :
                                     accept && sel_in == 3'd6 ? DIV : IDLE)
                                  : (last ? IDLE : state_q);
    end

    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        mc_d  = mc_q;
        mp_d  = mp_q;
        quo_d = quo_q;
        rem_d = rem_q;
        dvs_d = dvs_q;
        gtp_d = gtp_q;
        eqp_d = eqp_q;
        res_d = res_q;
        gt_d  = gt_q;
        eq_d  = eq_q;
        dz_d  = dz_q;
        vld_d = 1'b0;
        if (state_q == IDLE) begin
            if (accept) begin
                cnt_d = '0;
                acc_d = '0;
                mc_d  = W2'(d0_in);
                mp_d  = d1_in;
                quo_d = d0_in;
                rem_d = '0;
                dvs_d = d1_in;
                gtp_d = d0_in > d1_in;
                eqp_d = d0_in == d1_in;
                if (!multi) begin
                    res_d = alu;
                    gt_d  = d0_in > d1_in;
                    eq_d  = d0_in == d1_in;
                    dz_d  = 1'b0;
                    vld_d = 1'b1;
                end
            end
        end else begin
            cnt_d = last ? '0 : cnt_q + CW'(1);
            if (state_q == MUL) begin
                acc_d = mul_acc;
                mc_d  = mc_q << 1;
                mp_d  = mp_q >> 1;
            end else begin
                rem_d = div_rn;
                quo_d = div_qn;
            end
            // Flags are published only when the result lands.
            if (last) begin
                res_d = state_q == MUL ? mul_acc : {div_rn, div_qn};
                gt_d  = gtp_q;
                eq_d  = eqp_q;
                dz_d  = state_q == DIV && dvs_q == '0;
                vld_d = 1'b1;
            end
        end
    end

    always_comb begin
        ready_out    = state_q == IDLE;
        res_out      = res_q;
        gt_out       = gt_q;
        eq_out       = eq_q;
        div_zero_out = dz_q;
        valid_out    = vld_q;
    end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: scoreboard bench driving WIDTH 4/8/16 instances with directed vectors.
module tb_seq_alu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] d0 = '0, d1 = '0;
    logic [2:0]  sel = '0;
    logic        valid = 1'b0;
    int          tgt = 8;

    logic        rdy4, gt4, eq4, dz4, vo4;
    logic [7:0]  res4;
    logic        rdy8, gt8, eq8, dz8, vo8;
    logic [15:0] res8;
    logic        rdy16, gt16, eq16, dz16, vo16;
    logic [31:0] res16;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(4)) u4 (
        .clk_in(clk), .rst_in(rst), .d0_in(d0[3:0]), .d1_in(d1[3:0]), .sel_in(sel),
        .valid_in(valid && tgt == 4), .ready_out(rdy4), .res_out(res4), .gt_out(gt4),
        .eq_out(eq4), .div_zero_out(dz4), .valid_out(vo4)
    );
    seq_alu #(.WIDTH(8)) u8 (
        .clk_in(clk), .rst_in(rst), .d0_in(d0[7:0]), .d1_in(d1[7:0]), .sel_in(sel),
        .valid_in(valid && tgt == 8), .ready_out(rdy8), .res_out(res8), .gt_out(gt8),
        .eq_out(eq8), .div_zero_out(dz8), .valid_out(vo8)
    );
    seq_alu #(.WIDTH(16)) u16 (
        .clk_in(clk), .rst_in(rst), .d0_in(d0), .d1_in(d1), .sel_in(sel),
        .valid_in(valid && tgt == 16), .ready_out(rdy16), .res_out(res16), .gt_out(gt16),
        .eq_out(eq16), .div_zero_out(dz16), .valid_out(vo16)
    );

    typedef struct {
        int          tag;
        logic [31:0] res;
        logic        gt, eq, dz;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   pass = 0, total = 0, nc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic pop(input int tag, input logic [31:0] r, input logic g, input logic e, input logic z);
        exp_t x;
        total++;
        if (q.size() == 0) begin
            $display("FAIL unexpected pulse w%0d: got res=%h, none expected", tag, r);
        end else begin
            x = q.pop_front();
            if (x.tag == tag && x.res === r && x.gt === g && x.eq === e && x.dz === z && x.cyc == nc) pass++;
            else $display("FAIL result w%0d: got res=%h gt=%b eq=%b dz=%b cyc=%0d want w%0d res=%h gt=%b eq=%b dz=%b cyc=%0d",
                          tag, r, g, e, z, nc, x.tag, x.res, x.gt, x.eq, x.dz, x.cyc);
        end
    endtask

    always @(negedge clk) begin
        nc = nc + 1;
        if (vo4) pop(4, {24'b0, res4}, gt4, eq4, dz4);
        if (vo8) pop(8, {16'b0, res8}, gt8, eq8, dz8);
        if (vo16) pop(16, res16, gt16, eq16, dz16);
    end

    function automatic logic rdy(input int w);
        return w == 4 ? rdy4 : w == 8 ? rdy8 : rdy16;
    endfunction

    task automatic issue(input int w, input logic [15:0] a, input logic [15:0] b, input logic [2:0] s,
                         input logic [31:0] r, input logic g, input logic e, input logic z, input bit push);
        int n = 0;
        while (!rdy(w) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 100) begin
            total++;
            $display("FAIL ready timeout w%0d: got busy, want ready", w);
        end
        tgt = w; d0 = a; d1 = b; sel = s; valid = 1'b1;
        if (push) q.push_back('{w, r, g, e, z, nc + 2 + ((s == 3'd5 || s == 3'd6) ? w : 0)});
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    task automatic singles(input int w, input logic [15:0] a, input logic [15:0] b, input logic [0:5][31:0] e);
        for (int i = 0; i < 6; i++) issue(w, a, b, i == 5 ? 3'd7 : 3'(i), e[i], 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 200) begin
            total++;
            $display("FAIL drain timeout: got %0d pending, want 0", q.size());
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst ready", {29'b0, rdy4, rdy8, rdy16}, 32'h7);
        chk("rst valid", {29'b0, vo4, vo8, vo16}, 32'h0);
        chk("rst res8", {16'b0, res8}, 32'h0);
        chk("rst flags8", {29'b0, gt8, eq8, dz8}, 32'h0);
        chk("rst res16", res16, 32'h0);

        singles(8, 16'd12, 16'd45, {32'd57, 32'h0000FFDF, 32'h000C, 32'h002D, 32'h0021, 32'h2D0C});
        issue(8, 16'd255, 16'd255, 3'd5, 32'hFE01, 1'b0, 1'b1, 1'b0, 1'b1);
        tgt = 8; d0 = 16'd1; d1 = 16'd2; sel = 3'd0; valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("busy ready", {31'b0, rdy8}, 32'h0);
            @(posedge clk); #1;
        end
        valid = 1'b0;
        chk("ready back", {31'b0, rdy8}, 32'h1);
        issue(8, 16'd200, 16'd7, 3'd6, 32'h041C, 1'b1, 1'b0, 1'b0, 1'b1);
        issue(8, 16'd9, 16'd0, 3'd6, 32'h09FF, 1'b1, 1'b0, 1'b1, 1'b1);
        issue(8, 16'hF0, 16'h3C, 3'd2, 32'h0030, 1'b1, 1'b0, 1'b0, 1'b1);
        drain();

        issue(8, 16'd10, 16'd10, 3'd5, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort ready", {31'b0, rdy8}, 32'h1);
        chk("abort res", {16'b0, res8}, 32'h0);
        chk("abort flags", {28'b0, vo8, gt8, eq8, dz8}, 32'h0);
        repeat (12) begin
            @(posedge clk); #1;
        end
        issue(8, 16'd1, 16'd1, 3'd0, 32'd2, 1'b0, 1'b1, 1'b0, 1'b1);
        drain();

        singles(4, 16'd3, 16'd10, {32'h0D, 32'hF9, 32'h02, 32'h0B, 32'h09, 32'hA3});
        issue(4, 16'd15, 16'd15, 3'd5, 32'hE1, 1'b0, 1'b1, 1'b0, 1'b1);
        issue(4, 16'd13, 16'd3, 3'd6, 32'h14, 1'b1, 1'b0, 1'b0, 1'b1);
        issue(4, 16'd9, 16'd0, 3'd6, 32'h9F, 1'b1, 1'b0, 1'b1, 1'b1);
        issue(4, 16'd12, 16'd5, 3'd2, 32'h04, 1'b1, 1'b0, 1'b0, 1'b1);
        drain();

        singles(16, 16'h1234, 16'hF00F, {32'h00010243, 32'hFFFF2225, 32'h1004, 32'hF23F, 32'hE23B, 32'hF00F1234});
        issue(16, 16'hFFFF, 16'hFFFF, 3'd5, 32'hFFFE0001, 1'b0, 1'b1, 1'b0, 1'b1);
        issue(16, 16'hFFFF, 16'h0100, 3'd6, 32'h00FF00FF, 1'b1, 1'b0, 1'b0, 1'b1);
        issue(16, 16'd9, 16'd0, 3'd6, 32'h0009FFFF, 1'b1, 1'b0, 1'b1, 1'b1);
        issue(16, 16'hF0F0, 16'h0FF0, 3'd2, 32'h00F0, 1'b1, 1'b0, 1'b0, 1'b1);
        drain();

        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("scoreboard empty", 32'(q.size()), 32'h0);
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1);
    end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, clocked successor to the 8-bit combinational ALU.
- Operands are WIDTH bits wide and results are 2*WIDTH bits wide.
- Single-cycle ops (add/sub/logic/concat) are registered. Multiply and divide run as iterative multi-cycle ops.
- A valid/ready handshake lets upstream control logic or a UART command decoder issue operations and collect flagged results.

Parameters:
WIDTH  8  operand width in bits; result width is 2*WIDTH; WIDTH must be >= 2

Ports:
clk_in        input   1        system clock, rising edge
rst_in        input   1        synchronous active-high reset
d0_in         input   WIDTH    operand A (unsigned)
d1_in         input   WIDTH    operand B (unsigned)
sel_in        input   3        operation select
valid_in      input   1        operation request
ready_out     output  1        block can accept a request this cycle
res_out       output  2*WIDTH  result
gt_out        output  1        d0 > d1 (unsigned), captured at accept
eq_out        output  1        d0 == d1, captured at accept
div_zero_out  output  1        last divide had d1 == 0
valid_out     output  1        one-cycle pulse: res/flags updated

Behaviour:
- Accept: a request is taken on a rising edge where valid_in && ready_out. Operands, sel_in and the compare flags are captured on that edge. valid_in while ready_out is low is ignored, with no queuing.
- Reset (sync): state=IDLE, ready_out=1, valid_out=0, res_out=0, gt_out=0, eq_out=0, div_zero_out=0, iteration counter=0.
- Reset asserted mid-operation aborts the operation; no valid_out pulse is produced for it.
- sel_in encoding:
  - 0 add: zero-extended d0+d1, carry in bit WIDTH.
  - 1 sub: d0-d1, sign-extended two's complement to 2*WIDTH.
  - 2 and, 3 or, 4 xor: zero-extended.
  - 5 mul: unsigned d0*d1, iterative.
  - 6 div: unsigned. Quotient in res_out[WIDTH-1:0], remainder in res_out[2*WIDTH-1:WIDTH]. Iterative.
  - 7 concat: {d1,d0}.
- Single-cycle ops (sel 0-4, 7), accepted at edge N:
  - res_out and flags are registered at edge N; valid_out is high for exactly the cycle after N.
  - ready_out stays high, giving back-to-back throughput of 1 op per cycle.
  - div_zero_out clears to 0 on any non-divide result.
- FSM states: IDLE, MUL, DIV.
  - IDLE -> MUL on accepted sel=5; IDLE -> DIV on accepted sel=6.
  - At accept edge N the working registers are loaded and ready_out goes low from the next cycle.
  - One iteration runs per edge, N+1 through N+WIDTH. MUL uses shift-add (one multiplier bit per edge). DIV uses restoring division (one quotient bit per edge).
  - At edge N+WIDTH: res_out is written, valid_out pulses for one cycle, ready_out returns high, and state returns to IDLE.
  - The earliest next accept is edge N+WIDTH+1. Latency is WIDTH cycles; throughput is 1 op per WIDTH+1 cycles.
- Divide by zero (d1==0):
  - Runs the full WIDTH iterations; no early exit.
  - Result: quotient all ones, remainder = d0, div_zero_out=1 with the valid_out pulse.
- Outputs hold their last value between valid_out pulses. gt_out and eq_out always reflect the operands of the most recently completed op.
- While busy, changes on d0_in, d1_in or sel_in must not affect the in-flight op.
- Widths: all internal arithmetic is unsigned 2*WIDTH. There are no overflow flags; mul of max*max = (2^WIDTH-1)^2 must fit exactly.

Test Plan:
- WIDTH=8, rst_in held 2 cycles, then released:
  - -> ready_out=1, valid_out=0, res_out=0, all flags 0.
- d0=12, d1=45, sel=0..4,7 issued back-to-back, one per cycle:
  - -> six consecutive valid_out pulses, each one cycle after its accept.
  - -> res_out = 16'd57, 16'hFFDF, 16'h000C, 16'h002D, 16'h0021, 16'h2D0C.
  - -> gt_out=0, eq_out=0 on every result.
- d0=255, d1=255, sel=5:
  - -> ready_out low for 8 cycles; valid_out 8 cycles after accept.
  - -> res_out=16'hFE01, eq_out=1.
  - valid_in held high during busy with sel=0: ignored, with no extra pulse.
- d0=200, d1=7, sel=6:
  - -> res_out=16'h041C (quotient 28, remainder 4), gt_out=1, div_zero_out=0.
  - Follow with d0=9, d1=0, sel=6: -> res_out=16'h09FF, div_zero_out=1.
  - Then sel=2: div_zero_out clears to 0.
- Start sel=5 with d0=10, d1=10; pulse rst_in at accept+3:
  - -> no valid_out pulse; outputs zero; ready_out=1 next cycle.
  - A new add 1+1 then returns 16'd2.
- Re-run scenarios 2-4 at WIDTH=4 (mul 15*15 -> 8'hE1, latency 4 cycles) and WIDTH=16 (div 16'hFFFF/16'h0100 -> 32'h00FF00FF).
